// File: rtl/uart_regs_access_ctrl.sv
// UART register-file bus owner: programs divisor/LCR/FCR/IER after reset, then
// round-robins single-cycle register accesses between a host and a TX feeder.
module uart_regs_access_ctrl #(
    parameter int          ADDR_W  = 3,
    parameter logic [15:0] DIVISOR = 16'd27,
    parameter logic [7:0]  LCR_VAL = 8'h03,
    parameter logic [7:0]  FCR_VAL = 8'hC6,
    parameter logic [7:0]  IER_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    input  logic              reinit,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [7:0]        h_wdat,
    output logic              h_ack,
    output logic [7:0]        h_rdat,
    input  logic              f_req,
    input  logic [7:0]        f_wdat,
    output logic              f_ack,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [7:0]        reg_dat_o,
    output logic              reg_we_o,
    output logic              reg_re_o,
    input  logic [7:0]        reg_dat_i,
    output logic              init_done,
    output logic              dlab_o
);

    localparam logic [3:0] I_LCRD  = 4'd0;
    localparam logic [3:0] I_DLL   = 4'd1;
    localparam logic [3:0] I_DLM   = 4'd2;
    localparam logic [3:0] I_LCR   = 4'd3;
    localparam logic [3:0] I_FCR   = 4'd4;
    localparam logic [3:0] I_IER   = 4'd5;
    localparam logic [3:0] S_ARB   = 4'd6;
    localparam logic [3:0] S_ISSUE = 4'd7;
    localparam logic [3:0] S_ACK   = 4'd8;

    localparam logic [ADDR_W-1:0] A_TR = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_IE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_FC = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_LC = ADDR_W'(3);

    logic [3:0]        state_q, state_d;
    logic              rst_q;
    logic              init_done_q;
    logic              dlab_q;
    logic              last_grant_q;
    logic              gnt_f_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdat_q;
    logic [7:0]        h_rdat_q;
    logic              reinit_pend_q;
    logic              f_eff;
    logic              gnt_f;

    // Feeder targets address 0, which is DLL while DLAB is set.
    assign f_eff = f_req & ~dlab_q;
    assign gnt_f = f_eff & (~h_req | ~last_grant_q);

    assign h_ack     = (state_q == S_ACK) & ~gnt_f_q;
    assign f_ack     = (state_q == S_ACK) &  gnt_f_q;
    assign h_rdat    = h_rdat_q;
    assign init_done = init_done_q;
    assign dlab_o    = dlab_q;

    // rst_q keeps the bus quiet for the cycle following a reset edge.
    always_comb begin
        reg_addr_o = addr_q;
        reg_dat_o  = wdat_q;
        reg_we_o   = 1'b0;
        reg_re_o   = 1'b0;
        if (!rst_q) begin
            case (state_q)
                I_LCRD:  begin reg_addr_o = A_LC; reg_dat_o = LCR_VAL | 8'h80;  reg_we_o = 1'b1; end
                I_DLL:   begin reg_addr_o = A_TR; reg_dat_o = DIVISOR[7:0];     reg_we_o = 1'b1; end
                I_DLM:   begin reg_addr_o = A_IE; reg_dat_o = DIVISOR[15:8];    reg_we_o = 1'b1; end
                I_LCR:   begin reg_addr_o = A_LC; reg_dat_o = LCR_VAL;          reg_we_o = 1'b1; end
                I_FCR:   begin reg_addr_o = A_FC; reg_dat_o = FCR_VAL;          reg_we_o = 1'b1; end
                I_IER:   begin reg_addr_o = A_IE; reg_dat_o = IER_VAL;          reg_we_o = 1'b1; end
                S_ISSUE: begin reg_we_o = we_q; reg_re_o = ~we_q; end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            I_LCRD, I_DLL, I_DLM, I_LCR, I_FCR: state_d = state_q + 4'd1;
            I_IER:   state_d = S_ARB;
            S_ARB:   if (reinit) state_d = I_LCRD;
                     else if (h_req || f_eff) state_d = S_ISSUE;
            S_ISSUE: state_d = S_ACK;
            S_ACK:   state_d = (reinit_pend_q || reinit) ? I_LCRD : S_ARB;
            default: state_d = I_LCRD;
        endcase
        if (reinit && state_q <= I_IER) state_d = I_LCRD;
        if (rst_q) state_d = I_LCRD;
    end

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            state_q       <= I_LCRD;
            rst_q         <= 1'b1;
            init_done_q   <= 1'b0;
            dlab_q        <= 1'b0;
            last_grant_q  <= 1'b0;
            gnt_f_q       <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdat_q        <= 8'h00;
            h_rdat_q      <= 8'h00;
            reinit_pend_q <= 1'b0;
        end else begin
            rst_q   <= 1'b0;
            state_q <= state_d;
            if (!rst_q) begin
                case (state_q)
                    I_LCRD: dlab_q <= 1'b1;
                    I_LCR:  dlab_q <= 1'b0;
                    I_IER:  init_done_q <= ~reinit;
                    S_ARB: begin
                        if (reinit) begin
                            init_done_q <= 1'b0;
                        end else if (h_req || f_eff) begin
                            gnt_f_q <= gnt_f;
                            we_q    <= gnt_f | h_we;
                            addr_q  <= gnt_f ? A_TR : h_addr;
                            wdat_q  <= gnt_f ? f_wdat : h_wdat;
                        end
                    end
                    S_ISSUE: begin
                        if (reinit) reinit_pend_q <= 1'b1;
                        if (!we_q) h_rdat_q <= reg_dat_i;
                        else if (!gnt_f_q && addr_q == A_LC) dlab_q <= wdat_q[7];
                    end
                    S_ACK: begin
                        last_grant_q <= gnt_f_q;
                        if (reinit_pend_q || reinit) begin
                            init_done_q   <= 1'b0;
                            reinit_pend_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_regs_access_ctrl.sv
// Directed bench for uart_regs_access_ctrl; inputs driven and outputs sampled on negedge.
module tb_uart_regs_access_ctrl;
    logic       clk = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic       reinit = 1'b0;
    logic       h_req = 1'b0, h_we = 1'b0;
    logic [2:0] h_addr = 3'd0;
    logic [7:0] h_wdat = 8'h00;
    logic       h_ack;
    logic [7:0] h_rdat;
    logic       f_req = 1'b0;
    logic [7:0] f_wdat = 8'h00;
    logic       f_ack;
    logic [2:0] reg_addr_o;
    logic [7:0] reg_dat_o;
    logic       reg_we_o, reg_re_o;
    logic [7:0] reg_dat_i = 8'h60;
    logic       init_done, dlab_o;

    int tests = 0;
    int fails = 0;

    logic [2:0] ea [6] = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2, 3'd1};
    logic [7:0] ed [6] = '{8'h83, 8'h1B, 8'h00, 8'h03, 8'hC6, 8'h00};

    uart_regs_access_ctrl dut (
        .clk(clk), .wb_rst_i(wb_rst_i), .reinit(reinit),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdat(h_wdat),
        .h_ack(h_ack), .h_rdat(h_rdat),
        .f_req(f_req), .f_wdat(f_wdat), .f_ack(f_ack),
        .reg_addr_o(reg_addr_o), .reg_dat_o(reg_dat_o),
        .reg_we_o(reg_we_o), .reg_re_o(reg_re_o), .reg_dat_i(reg_dat_i),
        .init_done(init_done), .dlab_o(dlab_o)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        @(negedge clk); wb_rst_i = 1'b1;
        @(negedge clk); wb_rst_i = 1'b0;
        tests++;
        if ({reg_we_o, reg_re_o, h_ack, f_ack, init_done, dlab_o, h_rdat} !== 14'h0) begin
            fails++;
            $display("FAIL reset_state: we=%b re=%b hack=%b fack=%b done=%b dlab=%b rdat=%h, want all 0",
                     reg_we_o, reg_re_o, h_ack, f_ack, init_done, dlab_o, h_rdat);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            tests++;
            if (reg_we_o !== 1'b1 || reg_re_o !== 1'b0 || reg_addr_o !== ea[k-1] ||
                reg_dat_o !== ed[k-1] || init_done !== 1'b0 || dlab_o !== (k >= 2 && k <= 4)) begin
                fails++;
                $display("FAIL init_write%0d: we=%b re=%b addr=%0d dat=%h done=%b dlab=%b, want we=1 addr=%0d dat=%h done=0 dlab=%b",
                         k, reg_we_o, reg_re_o, reg_addr_o, reg_dat_o, init_done, dlab_o,
                         ea[k-1], ed[k-1], (k >= 2 && k <= 4));
            end
        end
        @(negedge clk);
        tests++;
        if (init_done !== 1'b1 || reg_we_o !== 1'b0 || dlab_o !== 1'b0) begin
            fails++;
            $display("FAIL init_done: done=%b we=%b dlab=%b, want 1 0 0", init_done, reg_we_o, dlab_o);
        end
    endtask

    task automatic test_host_read;
        h_req = 1'b1; h_we = 1'b0; h_addr = 3'd5;
        @(negedge clk);
        tests++;
        if (reg_re_o !== 1'b1 || reg_we_o !== 1'b0 || reg_addr_o !== 3'd5 || h_ack !== 1'b0) begin
            fails++;
            $display("FAIL read_issue: re=%b we=%b addr=%0d hack=%b, want 1 0 5 0", reg_re_o, reg_we_o, reg_addr_o, h_ack);
        end
        @(negedge clk);
        tests++;
        if (h_ack !== 1'b1 || h_rdat !== 8'h60 || reg_re_o !== 1'b0) begin
            fails++;
            $display("FAIL read_ack: hack=%b rdat=%h re=%b, want 1 60 0", h_ack, h_rdat, reg_re_o);
        end
        h_req = 1'b0;
        reg_dat_i = 8'h11;
        @(negedge clk);
        tests++;
        if (h_ack !== 1'b0 || h_rdat !== 8'h60 || reg_re_o !== 1'b0) begin
            fails++;
            $display("FAIL read_hold: hack=%b rdat=%h re=%b, want 0 60 0", h_ack, h_rdat, reg_re_o);
        end
    endtask

    task automatic test_feeder;
        f_req = 1'b1; f_wdat = 8'hA5;
        @(negedge clk);
        tests++;
        if (reg_we_o !== 1'b1 || reg_re_o !== 1'b0 || reg_addr_o !== 3'd0 || reg_dat_o !== 8'hA5) begin
            fails++;
            $display("FAIL feed_issue: we=%b re=%b addr=%0d dat=%h, want 1 0 0 a5", reg_we_o, reg_re_o, reg_addr_o, reg_dat_o);
        end
        @(negedge clk);
        tests++;
        if (f_ack !== 1'b1 || h_ack !== 1'b0) begin
            fails++;
            $display("FAIL feed_ack: fack=%b hack=%b, want 1 0", f_ack, h_ack);
        end
        f_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic host;
        logic prev_strobe;
        prev_strobe = 1'b0;
        h_req = 1'b1; h_we = 1'b1; h_addr = 3'd4; h_wdat = 8'h11;
        f_req = 1'b1; f_wdat = 8'h22;
        for (int i = 0; i < 4; i++) begin
            host = (i % 2 == 0);
            @(negedge clk);
            tests++;
            if (reg_we_o !== 1'b1 || prev_strobe !== 1'b0 ||
                reg_addr_o !== (host ? 3'd4 : 3'd0) || reg_dat_o !== (host ? 8'h11 : 8'h22)) begin
                fails++;
                $display("FAIL b2b_issue%0d: we=%b prev=%b addr=%0d dat=%h, want we=1 prev=0 addr=%0d dat=%h",
                         i, reg_we_o, prev_strobe, reg_addr_o, reg_dat_o, host ? 3'd4 : 3'd0, host ? 8'h11 : 8'h22);
            end
            prev_strobe = reg_we_o | reg_re_o;
            @(negedge clk);
            tests++;
            if (h_ack !== host || f_ack !== !host || (reg_we_o | reg_re_o) !== 1'b0) begin
                fails++;
                $display("FAIL b2b_ack%0d: hack=%b fack=%b strobe=%b, want hack=%b fack=%b strobe=0",
                         i, h_ack, f_ack, reg_we_o | reg_re_o, host, !host);
            end
            prev_strobe = reg_we_o | reg_re_o;
            if (i == 3) begin h_req = 1'b0; f_req = 1'b0; end
            @(negedge clk);
            prev_strobe = reg_we_o | reg_re_o;
        end
    endtask

    task automatic test_dlab_block;
        h_req = 1'b1; h_we = 1'b1; h_addr = 3'd3; h_wdat = 8'h83;
        @(negedge clk);
        @(negedge clk);
        h_req = 1'b0; f_req = 1'b1; f_wdat = 8'h5A;
        @(negedge clk);
        tests++;
        if (dlab_o !== 1'b1) begin
            fails++;
            $display("FAIL dlab_set: dlab=%b, want 1", dlab_o);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (reg_we_o !== 1'b0 || f_ack !== 1'b0) begin
                fails++;
                $display("FAIL dlab_block%0d: we=%b fack=%b, want 0 0", k, reg_we_o, f_ack);
            end
        end
        h_req = 1'b1; h_wdat = 8'h03;
        @(negedge clk);
        tests++;
        if (reg_we_o !== 1'b1 || reg_addr_o !== 3'd3 || reg_dat_o !== 8'h03) begin
            fails++;
            $display("FAIL dlab_clear_issue: we=%b addr=%0d dat=%h, want 1 3 03", reg_we_o, reg_addr_o, reg_dat_o);
        end
        @(negedge clk);
        h_req = 1'b0;
        @(negedge clk);
        tests++;
        if (dlab_o !== 1'b0) begin
            fails++;
            $display("FAIL dlab_clear: dlab=%b, want 0", dlab_o);
        end
        @(negedge clk);
        tests++;
        if (reg_we_o !== 1'b1 || reg_addr_o !== 3'd0 || reg_dat_o !== 8'h5A) begin
            fails++;
            $display("FAIL feed_after_dlab: we=%b addr=%0d dat=%h, want 1 0 5a", reg_we_o, reg_addr_o, reg_dat_o);
        end
        @(negedge clk);
        tests++;
        if (f_ack !== 1'b1) begin
            fails++;
            $display("FAIL feed_after_dlab_ack: fack=%b, want 1", f_ack);
        end
        f_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reinit;
        int budget;
        h_req = 1'b1; h_we = 1'b1; h_addr = 3'd7; h_wdat = 8'h99;
        @(negedge clk);
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        tests++;
        if (h_ack !== 1'b1 || init_done !== 1'b1) begin
            fails++;
            $display("FAIL reinit_ack: hack=%b done=%b, want 1 1", h_ack, init_done);
        end
        h_req = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            tests++;
            if (reg_we_o !== 1'b1 || reg_addr_o !== ea[k-1] || reg_dat_o !== ed[k-1] || init_done !== 1'b0) begin
                fails++;
                $display("FAIL reinit_write%0d: we=%b addr=%0d dat=%h done=%b, want 1 %0d %h 0",
                         k, reg_we_o, reg_addr_o, reg_dat_o, init_done, ea[k-1], ed[k-1]);
            end
        end
        @(negedge clk);
        tests++;
        if (init_done !== 1'b1) begin
            fails++;
            $display("FAIL reinit_done: done=%b, want 1", init_done);
        end
        // A reinit pulse while idle restarts init on the very next cycle.
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        tests++;
        if (init_done !== 1'b0 || reg_we_o !== 1'b1 || reg_addr_o !== 3'd3 || reg_dat_o !== 8'h83) begin
            fails++;
            $display("FAIL reinit_idle: done=%b we=%b addr=%0d dat=%h, want 0 1 3 83", init_done, reg_we_o, reg_addr_o, reg_dat_o);
        end
        budget = 0;
        while (init_done !== 1'b1 && budget < 20) begin @(negedge clk); budget++; end
        tests++;
        if (init_done !== 1'b1) begin
            fails++;
            $display("FAIL reinit_idle_timeout: done=%b after %0d cycles, want 1", init_done, budget);
        end
    endtask

    task automatic test_reset_mid;
        int budget;
        logic acked;
        acked = 1'b0;
        f_req = 1'b1; f_wdat = 8'h77;
        @(negedge clk);
        tests++;
        if (reg_we_o !== 1'b1 || reg_addr_o !== 3'd0 || reg_dat_o !== 8'h77) begin
            fails++;
            $display("FAIL rst_mid_issue: we=%b addr=%0d dat=%h, want 1 0 77", reg_we_o, reg_addr_o, reg_dat_o);
        end
        wb_rst_i = 1'b1;
        @(negedge clk);
        wb_rst_i = 1'b0; f_req = 1'b0;
        acked = acked | f_ack;
        tests++;
        if (reg_we_o !== 1'b0 || init_done !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_quiet: we=%b done=%b, want 0 0", reg_we_o, init_done);
        end
        @(negedge clk);
        acked = acked | f_ack;
        tests++;
        if (reg_we_o !== 1'b1 || reg_addr_o !== 3'd3 || reg_dat_o !== 8'h83) begin
            fails++;
            $display("FAIL rst_mid_restart: we=%b addr=%0d dat=%h, want 1 3 83", reg_we_o, reg_addr_o, reg_dat_o);
        end
        budget = 0;
        while (init_done !== 1'b1 && budget < 20) begin
            @(negedge clk); budget++;
            acked = acked | f_ack;
        end
        tests++;
        if (acked !== 1'b0 || init_done !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_noack: fack_seen=%b done=%b, want 0 1", acked, init_done);
        end
    endtask

    initial begin
        test_reset();
        test_host_read();
        test_feeder();
        test_back_to_back();
        test_dlab_block();
        test_reinit();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
